sad_min_search: RTL and testbench
=================================

SAD_MIN_SEARCH -- requirements
Module: sad_min_search

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PIX_W, 8, pixel bit width.
- LANES, 4, pixels per input beat.
- BLK_PIX, 64, pixels per candidate block; power of two and a multiple of LANES.
- SR_W, 4, candidate columns per search row; at most 2^POS_W.
- POS_W, 5, width of each position coordinate.
- EARLY_TERM, 1, enables partial-SAD rejection (1 = on).
- Derived: BEATS = BLK_PIX/LANES; SAD_W = PIX_W + clog2(BLK_PIX).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- start_i, in, 1, begins a search; honoured only in IDLE.
- pix_valid_i, in, 1, beat valid.
- cur_pix_i, in, LANES*PIX_W, current-block pixels; lane 0 in the LSBs.
- ref_pix_i, in, LANES*PIX_W, reference pixels, lane-aligned with cur_pix_i.
- search_last_i, in, 1, marks the final candidate of the search; sampled on that candidate's last beat.
- in_ready_o, out, 1, beat accepted when pix_valid_i and in_ready_o are both high.
- reject_o, out, 1, one-cycle pulse when a candidate is early-terminated.
- MSAD, out, SAD_W, minimum SAD found.
- MSAD_row, out, POS_W, row of the winning candidate.
- MSAD_column, out, POS_W, column of the winning candidate.
- cand_cnt_o, out, 2*POS_W, number of candidates evaluated.
- data_valid, out, 1, one-cycle result pulse.

Function
REQ-003 States: IDLE, RUN, FLUSH, DONE. in_ready_o SHALL be high only in RUN.
REQ-004 IDLE -> RUN on start_i. Entry SHALL clear the beat counter, the row/column counters, the accumulator, cand_cnt_o and the min-valid flag.
REQ-005 start_i SHALL be ignored in RUN, FLUSH and DONE.
REQ-006 Each accepted beat SHALL compute per-lane |cur-ref| unsigned, registered (stage 1), then the lane sum plus accumulator, registered (stage 2). The accumulator is SAD_W bits and SHALL never overflow.
REQ-007 The beat counter SHALL count 0..BEATS-1. The beat with count BEATS-1 closes the candidate; the accumulator restarts at 0 for the next candidate with no bubble.
REQ-008 Candidate compare SHALL occur the cycle after stage 2 of the closing beat. The min registers update iff the min-valid flag is clear, or SAD < MSAD (strictly less), and the candidate was not rejected.
- Ties keep the earlier candidate in scan order.
REQ-009 Position counters SHALL track the current candidate: the column increments per closed candidate and wraps from SR_W-1 to 0, incrementing the row. Row wrap is modulo 2^POS_W.
REQ-010 When EARLY_TERM=1 and min-valid is set, the first stage-2 partial sum strictly greater than MSAD SHALL mark the candidate rejected and pulse reject_o once.
- Remaining beats of a rejected candidate are still consumed and counted.
- When EARLY_TERM=0, reject_o stays 0.
REQ-011 The final MSAD, MSAD_row and MSAD_column SHALL be identical for EARLY_TERM=0 and EARLY_TERM=1 on the same stimulus.
REQ-012 cand_cnt_o SHALL increment once per closed candidate, whether rejected or not.
REQ-013 A closing beat with search_last_i=1 SHALL move RUN -> FLUSH, holding in_ready_o low. FLUSH lasts until the last compare completes (2 cycles). Then FLUSH -> DONE.
REQ-014 In DONE, data_valid SHALL pulse for exactly 1 cycle, with MSAD, MSAD_row, MSAD_column and cand_cnt_o final. The state then returns to IDLE.
- Result latency is 4 cycles from acceptance of the final beat.
REQ-015 Results SHALL hold stable after data_valid until the next RUN entry.
REQ-016 pix_valid_i gaps (valid low) in RUN SHALL stall all counters with no state change. The pipeline stages still drain.
REQ-017 search_last_i on a non-closing beat SHALL be ignored.

Reset
REQ-018 rst SHALL force IDLE on the next clk edge regardless of state, aborting any search in progress.
REQ-019 Reset values SHALL be: in_ready_o=0, reject_o=0, data_valid=0, MSAD=0, MSAD_row=0, MSAD_column=0, cand_cnt_o=0. All internal counters, pipeline registers and the min-valid flag are cleared.
REQ-020 A start_i asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-021 Defaults, 16 candidates (4x4), all-zero cur, ref equal to 0x10 except candidate (2,1) equal to 0x00 -> MSAD=0x0000 at (row 2, col 1), cand_cnt_o=16, data_valid 1 cycle, 4 cycles after the last beat.
REQ-022 All candidates identical, |diff|=1 per pixel -> MSAD=64 at (0,0), confirming tie keeps the first.
REQ-023 cur=0xFF, ref=0x00 for all candidates -> MSAD=16320 (0x3FC0), no overflow, reject_o never pulses.
REQ-024 EARLY_TERM=1, candidate 0 SAD=10, candidate 1 with |diff|=20 on beat 0 -> reject_o pulses once during candidate 1, result MSAD=10 at (0,0), cand_cnt_o counts 2. The same run with EARLY_TERM=0 gives an identical result.
REQ-025 Random pix_valid_i gaps (about 30% low) -> result identical to the gap-free run.
REQ-026 rst asserted mid-RUN at beat 7 of candidate 3 -> all outputs 0 next cycle. A fresh start_i then gives a correct full search.

Source files
------------

// File: rtl/sad_min_search.sv
// Block-matching motion search: streams candidate blocks, accumulates SAD in a
// two-stage pipeline and keeps the minimum SAD with its (row, column) position.
module sad_min_search #(
    parameter  int unsigned PIX_W      = 8,
    parameter  int unsigned LANES      = 4,
    parameter  int unsigned BLK_PIX    = 64,
    parameter  int unsigned SR_W       = 4,
    parameter  int unsigned POS_W      = 5,
    parameter  int unsigned EARLY_TERM = 1,
    localparam int unsigned SAD_W      = PIX_W + $clog2(BLK_PIX),
    localparam int unsigned CNT_W      = 2 * POS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   pix_valid_i,
    input  logic [LANES*PIX_W-1:0] cur_pix_i,
    input  logic [LANES*PIX_W-1:0] ref_pix_i,
    input  logic                   search_last_i,
    output logic                   in_ready_o,
    output logic                   reject_o,
    output logic [SAD_W-1:0]       MSAD,
    output logic [POS_W-1:0]       MSAD_row,
    output logic [POS_W-1:0]       MSAD_column,
    output logic [CNT_W-1:0]       cand_cnt_o,
    output logic                   data_valid
);
    localparam int unsigned BEATS  = BLK_PIX / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic                flush_q, in_ready_q, reject_q, data_valid_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [POS_W-1:0]    row_q, col_q;
    logic [PIX_W-1:0]    s1_diff_q [LANES];
    logic                s1_valid_q, s1_first_q, s1_close_q;
    logic [POS_W-1:0]    s1_row_q, s1_col_q;
    logic [SAD_W-1:0]    s2_sum_q;
    logic                s2_valid_q, s2_close_q;
    logic [POS_W-1:0]    s2_row_q, s2_col_q;
    logic [SAD_W-1:0]    msad_q;
    logic [POS_W-1:0]    mrow_q, mcol_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                min_valid_q, rej_q;

    logic                accept_c, close_c, entry_c, reject_c, update_c;
    logic [PIX_W-1:0]    diff_c [LANES];
    logic [SAD_W-1:0]    lane_sum_c;

    assign accept_c = pix_valid_i && in_ready_q;
    assign close_c  = accept_c && (beat_q == BEAT_W'(BEATS - 1));
    assign entry_c  = (state_q == IDLE) && start_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FLUSH spans the two cycles the last candidate needs to compare
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (close_c && search_last_i) state_d = FLUSH;
            FLUSH:   if (flush_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-lane absolute difference and lane sum
    always_comb begin
        lane_sum_c = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            diff_c[l] = (cur_pix_i[l*PIX_W +: PIX_W] > ref_pix_i[l*PIX_W +: PIX_W])
                      ? cur_pix_i[l*PIX_W +: PIX_W] - ref_pix_i[l*PIX_W +: PIX_W]
                      : ref_pix_i[l*PIX_W +: PIX_W] - cur_pix_i[l*PIX_W +: PIX_W];
            lane_sum_c = lane_sum_c + SAD_W'(s1_diff_q[l]);
        end
    end

    // Partial sums only grow, so a rejected candidate can never win its compare
    always_comb begin
        reject_c = (EARLY_TERM != 0) && s2_valid_q && min_valid_q && !rej_q
                && (s2_sum_q > msad_q);
        update_c = s2_valid_q && s2_close_q && !rej_q && !reject_c
                && (!min_valid_q || (s2_sum_q < msad_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            reject_q     <= 1'b0;
            data_valid_q <= 1'b0;
            beat_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            for (int l = 0; l < int'(LANES); l++) s1_diff_q[l] <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_close_q   <= 1'b0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            s2_sum_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_close_q   <= 1'b0;
            s2_row_q     <= '0;
            s2_col_q     <= '0;
            msad_q       <= '0;
            mrow_q       <= '0;
            mcol_q       <= '0;
            cnt_q        <= '0;
            min_valid_q  <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            flush_q      <= (state_q == FLUSH);
            in_ready_q   <= (state_d == RUN);
            reject_q     <= reject_c;
            data_valid_q <= (state_d == DONE);

            // Stage 1
            s1_valid_q <= accept_c;
            if (accept_c) begin
                for (int l = 0; l < int'(LANES); l++) s1_diff_q[l] <= diff_c[l];
                s1_first_q <= (beat_q == '0);
                s1_close_q <= close_c;
                s1_row_q   <= row_q;
                s1_col_q   <= col_q;
            end

            // Stage 2: accumulator restarts on each candidate's first beat
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q   <= (s1_first_q ? '0 : s2_sum_q) + lane_sum_c;
                s2_close_q <= s1_close_q;
                s2_row_q   <= s1_row_q;
                s2_col_q   <= s1_col_q;
            end

            // Compare stage
            if (s2_valid_q && s2_close_q) begin
                rej_q <= 1'b0;
                cnt_q <= cnt_q + CNT_W'(1);
                if (update_c) begin
                    msad_q      <= s2_sum_q;
                    mrow_q      <= s2_row_q;
                    mcol_q      <= s2_col_q;
                    min_valid_q <= 1'b1;
                end
            end else if (reject_c) begin
                rej_q <= 1'b1;
            end

            // Beat and position counters
            if (accept_c) begin
                if (close_c) begin
                    beat_q <= '0;
                    if (col_q == POS_W'(SR_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + POS_W'(1);
                    end else begin
                        col_q <= col_q + POS_W'(1);
                    end
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end

            if (entry_c) begin
                beat_q      <= '0;
                row_q       <= '0;
                col_q       <= '0;
                s2_sum_q    <= '0;
                cnt_q       <= '0;
                min_valid_q <= 1'b0;
                rej_q       <= 1'b0;
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign reject_o    = reject_q;
    assign MSAD        = msad_q;
    assign MSAD_row    = mrow_q;
    assign MSAD_column = mcol_q;
    assign cand_cnt_o  = cnt_q;
    assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Bench for sad_min_search: a reference model fills a scoreboard per search;
// results of an early-terminating and a non-terminating instance are checked against it.
module tb_sad_min_search;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned BLK_PIX = 64;
    localparam int unsigned SR_W = 4;
    localparam int unsigned BEATS = BLK_PIX / LANES;

    typedef struct {
        logic [13:0] msad;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [9:0]  cnt;
        int          rej;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start_i, pix_valid_i, search_last_i;
    logic [LANES*PIX_W-1:0] cur_pix_i, ref_pix_i;
    logic in_ready_o, reject_o, data_valid, in_ready0, reject0, data_valid0;
    logic [13:0] MSAD, msad0;
    logic [4:0]  MSAD_row, MSAD_column, row0, col0;
    logic [9:0]  cand_cnt_o, cnt0;

    logic [7:0] cur_mem [16][64];
    logic [7:0] ref_mem [16][64];
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int rej1 = 0;
    int rej0 = 0;

    always #5 clk = ~clk;

    sad_min_search dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
        .cur_pix_i(cur_pix_i), .ref_pix_i(ref_pix_i), .search_last_i(search_last_i),
        .in_ready_o(in_ready_o), .reject_o(reject_o), .MSAD(MSAD), .MSAD_row(MSAD_row),
        .MSAD_column(MSAD_column), .cand_cnt_o(cand_cnt_o), .data_valid(data_valid)
    );

    sad_min_search #(.EARLY_TERM(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
        .cur_pix_i(cur_pix_i), .ref_pix_i(ref_pix_i), .search_last_i(search_last_i),
        .in_ready_o(in_ready0), .reject_o(reject0), .MSAD(msad0), .MSAD_row(row0),
        .MSAD_column(col0), .cand_cnt_o(cnt0), .data_valid(data_valid0)
    );

    always @(posedge clk) begin
        if (reject_o === 1'b1) rej1 <= rej1 + 1;
        if (reject0 === 1'b1) rej0 <= rej0 + 1;
    end

    // Reference: strict-less minimum in scan order, early rejection on partial sums
    task automatic model(input int ncand, output exp_t e);
        int sad, d, minv, rejd, min_sad;
        e = '{default: '0};
        minv = 0;
        min_sad = 0;
        for (int c = 0; c < ncand; c++) begin
            sad = 0;
            rejd = 0;
            for (int b = 0; b < int'(BEATS); b++) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    d = int'(cur_mem[c][b*LANES+l]) - int'(ref_mem[c][b*LANES+l]);
                    sad += (d < 0) ? -d : d;
                end
                if (minv != 0 && rejd == 0 && sad > min_sad) begin
                    rejd = 1;
                    e.rej++;
                end
            end
            if (rejd == 0 && (minv == 0 || sad < min_sad)) begin
                min_sad = sad;
                e.msad = 14'(sad);
                e.row = 5'(c / SR_W);
                e.col = 5'(c % SR_W);
                minv = 1;
            end
        end
        e.cnt = 10'(ncand);
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({in_ready_o, reject_o, data_valid, MSAD, MSAD_row, MSAD_column, cand_cnt_o} !== '0) begin
            bad++;
            $display("FAIL %s outputs got rdy=%b rej=%b dv=%b msad=%0d row=%0d col=%0d cnt=%0d required all 0",
                     tag, in_ready_o, reject_o, data_valid, MSAD, MSAD_row, MSAD_column, cand_cnt_o);
        end
    endtask

    task automatic run_search(input string tag, input int ncand, input int gap_pct,
                              input bit noise, input int abort_beat);
        exp_t e;
        int base1, base0, k, guard, idx;
        bit placed;
        model(ncand, e);
        if (abort_beat < 0) sb.push_back(e);
        base1 = rej1;
        base0 = rej0;
        @(negedge clk);
        start_i = 1'b1;
        for (int c = 0; c < ncand; c++) begin
            for (int b = 0; b < int'(BEATS); b++) begin
                placed = 1'b0;
                guard = 0;
                while (!placed) begin
                    @(negedge clk);
                    start_i = noise && ($urandom_range(0, 9) == 0);
                    guard++;
                    if (guard > 200) begin
                        $display("FAIL %s in_ready timeout", tag);
                        bad++;
                        total++;
                        return;
                    end
                    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                        pix_valid_i = 1'b0;
                        cur_pix_i = $urandom;
                        ref_pix_i = $urandom;
                        search_last_i = $urandom_range(0, 1) == 1;
                    end else begin
                        pix_valid_i = 1'b1;
                        for (int l = 0; l < int'(LANES); l++) begin
                            cur_pix_i[l*PIX_W +: PIX_W] = cur_mem[c][b*LANES+l];
                            ref_pix_i[l*PIX_W +: PIX_W] = ref_mem[c][b*LANES+l];
                        end
                        search_last_i = (b == int'(BEATS) - 1) ? (c == ncand - 1)
                                      : (noise && $urandom_range(0, 3) == 0);
                        idx = c * int'(BEATS) + b;
                        if (idx == abort_beat) rst = 1'b1;
                        placed = (in_ready_o === 1'b1);
                    end
                end
                if (abort_beat >= 0 && c * int'(BEATS) + b == abort_beat) begin
                    @(negedge clk);
                    check_zero({tag, "_abort"});
                    rst = 1'b0;
                    pix_valid_i = 1'b0;
                    search_last_i = 1'b0;
                    start_i = 1'b0;
                    return;
                end
            end
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                pix_valid_i = 1'b0;
                search_last_i = 1'b0;
                start_i = 1'b0;
                total++;
                if (in_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s flush_ready got=%b required=0", tag, in_ready_o);
                end
            end
        end while (data_valid !== 1'b1 && k < 50);
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL %s latency got=%0d cycles required=4 cycles", tag, k + 1);
        end
        e = sb.pop_front();
        total++;
        if (MSAD !== e.msad || MSAD_row !== e.row || MSAD_column !== e.col || cand_cnt_o !== e.cnt) begin
            bad++;
            $display("FAIL %s result got msad=%0d row=%0d col=%0d cnt=%0d required msad=%0d row=%0d col=%0d cnt=%0d",
                     tag, MSAD, MSAD_row, MSAD_column, cand_cnt_o, e.msad, e.row, e.col, e.cnt);
        end
        total++;
        if (data_valid0 !== 1'b1 || msad0 !== e.msad || row0 !== e.row || col0 !== e.col || cnt0 !== e.cnt) begin
            bad++;
            $display("FAIL %s noet_result got dv=%b msad=%0d row=%0d col=%0d cnt=%0d required msad=%0d row=%0d col=%0d cnt=%0d",
                     tag, data_valid0, msad0, row0, col0, cnt0, e.msad, e.row, e.col, e.cnt);
        end
        @(negedge clk);
        total++;
        if (data_valid !== 1'b0 || data_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL %s dv_width got=%b/%b required=0 on second cycle", tag, data_valid, data_valid0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (MSAD !== e.msad || MSAD_row !== e.row || MSAD_column !== e.col || cand_cnt_o !== e.cnt) begin
            bad++;
            $display("FAIL %s hold got msad=%0d row=%0d col=%0d cnt=%0d required msad=%0d",
                     tag, MSAD, MSAD_row, MSAD_column, cand_cnt_o, e.msad);
        end
        total++;
        if (rej1 - base1 != e.rej || rej0 - base0 != 0) begin
            bad++;
            $display("FAIL %s rejects got=%0d/%0d required=%0d/0", tag, rej1 - base1, rej0 - base0, e.rej);
        end
    endtask

    task automatic fill(input int cv, input int rv);
        for (int c = 0; c < 16; c++)
            for (int p = 0; p < 64; p++) begin
                cur_mem[c][p] = 8'(cv);
                ref_mem[c][p] = 8'(rv);
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready_o !== 1'b0 || in_ready0 !== 1'b0) begin
            bad++;
            $display("FAIL start_during_reset in_ready got=%b required=0", in_ready_o);
        end
    endtask

    task automatic test_min_pos();
        fill(0, 8'h10);
        for (int p = 0; p < 64; p++) ref_mem[9][p] = 8'h00;
        run_search("min_pos", 16, 0, 1'b0, -1);
    endtask

    task automatic test_tie();
        fill(8'h21, 8'h20);
        run_search("tie", 16, 0, 1'b0, -1);
    endtask

    task automatic test_max();
        fill(8'hFF, 8'h00);
        run_search("max", 16, 0, 1'b0, -1);
    endtask

    task automatic test_early_term();
        fill(0, 0);
        for (int p = 0; p < 10; p++) ref_mem[0][p] = 8'd1;
        for (int p = 0; p < 4; p++) ref_mem[1][p] = 8'd5;
        run_search("early_term", 2, 0, 1'b0, -1);
    endtask

    task automatic test_gaps();
        for (int c = 0; c < 16; c++)
            for (int p = 0; p < 64; p++) begin
                cur_mem[c][p] = 8'($urandom);
                ref_mem[c][p] = 8'($urandom);
            end
        run_search("random_nogap", 8, 0, 1'b0, -1);
        run_search("random_gap", 8, 30, 1'b1, -1);
    endtask

    task automatic test_abort();
        fill(0, 8'h10);
        for (int p = 0; p < 64; p++) ref_mem[9][p] = 8'h00;
        run_search("abort", 16, 0, 1'b0, 3 * int'(BEATS) + 7);
        repeat (2) @(negedge clk);
        run_search("after_abort", 16, 0, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        pix_valid_i = 1'b0;
        search_last_i = 1'b0;
        cur_pix_i = '0;
        ref_pix_i = '0;
        test_reset();
        test_min_pos();
        test_tie();
        test_max();
        test_early_term();
        test_gaps();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
